// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with an optional saturating match counter.
// Build macro SEQDET_MATCH_COUNT_EN enables o_match_cnt/o_cnt_sat; otherwise both are tied to 0.
module seq_detector_prog #(
  parameter int                 PAT_LEN = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(4'b0110)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_x,
  input  logic               i_x_valid,
  input  logic               i_pat_load,
  input  logic [PAT_LEN-1:0] i_pat_in,
  input  logic               i_overlap_en,
  input  logic               i_clr,
  output logic               o_z,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cnt_sat,
  output logic [PAT_LEN-1:0] o_pattern
);

  localparam int               FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_LEN-1:0] r_pat;
  logic               r_z;

  logic               w_accept;
  logic [PAT_LEN-1:0] w_hist_next;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_match;

  // pat_load and clr both swallow the bit presented alongside them
  assign w_accept    = i_x_valid && !i_pat_load && !i_clr;
  assign w_hist_next = {r_hist[PAT_LEN-2:0], i_x};
  assign w_fill_inc  = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FILL_W'(1);
  assign w_match     = w_accept && (w_hist_next == r_pat) && (w_fill_inc == FILL_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pat  <= PAT_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (i_pat_load) begin
      r_pat  <= i_pat_in;
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (i_clr) begin
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (i_x_valid) begin
      r_hist <= w_hist_next;
      r_z    <= w_match;
      r_fill <= (w_match && !i_overlap_en) ? '0 : w_fill_inc;
    end else begin
      r_z <= 1'b0;
    end
  end

  assign o_z       = r_z;
  assign o_pattern = r_pat;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_pat_load) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_sat <= ((r_cnt + CNT_W'(1)) == CNT_MAX);
    end
  end

  assign o_match_cnt = r_cnt;
  assign o_cnt_sat   = r_sat;
`else
  assign o_match_cnt = '0;
  assign o_cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two instances (default, and CNT_W=2 with pattern 1111)
// share stimulus and are checked every cycle against a bit-stream model.
module tb_seq_detector_prog;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic       clk;
  logic       i_reset, i_x, i_x_valid, i_pat_load, i_overlap_en, i_clr;
  logic [3:0] i_pat_in;
  logic       o_z0, o_z1, o_sat0, o_sat1;
  logic [7:0] o_cnt0;
  logic [1:0] o_cnt1;
  logic [3:0] o_pat0, o_pat1;

  seq_detector_prog dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_x(i_x), .i_x_valid(i_x_valid),
    .i_pat_load(i_pat_load), .i_pat_in(i_pat_in), .i_overlap_en(i_overlap_en),
    .i_clr(i_clr), .o_z(o_z0), .o_match_cnt(o_cnt0), .o_cnt_sat(o_sat0),
    .o_pattern(o_pat0)
  );

  seq_detector_prog #(.PAT_LEN(4), .CNT_W(2), .PAT_RST(4'b1111)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_x(i_x), .i_x_valid(i_x_valid),
    .i_pat_load(i_pat_load), .i_pat_in(i_pat_in), .i_overlap_en(i_overlap_en),
    .i_clr(i_clr), .o_z(o_z1), .o_match_cnt(o_cnt1), .o_cnt_sat(o_sat1),
    .o_pattern(o_pat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: keep the list of bits accepted since the last flush; a match is
  // simply "the last four accepted bits spell the pattern".
  bit        m_ok = 1'b0;
  bit        m_stream [0:1][0:1023];
  int        m_len [0:1];
  logic [3:0] m_pat [0:1];
  bit        m_z [0:1];
  int        m_cnt [0:1];
  int        cmax [0:1];
  logic [3:0] prst [0:1];

  initial begin
    cmax[0] = 255; cmax[1] = 3;
    prst[0] = 4'b0110; prst[1] = 4'b1111;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (i_reset) begin
        m_pat[k] = prst[k]; m_len[k] = 0; m_z[k] = 0; m_cnt[k] = 0;
      end else if (i_pat_load) begin
        m_pat[k] = i_pat_in; m_len[k] = 0; m_z[k] = 0; m_cnt[k] = 0;
      end else if (i_clr) begin
        m_len[k] = 0; m_z[k] = 0;
      end else if (i_x_valid) begin
        bit hit;
        m_stream[k][m_len[k]] = i_x;
        m_len[k]++;
        hit = (m_len[k] >= 4);
        if (hit)
          for (int j = 0; j < 4; j++)
            if (m_stream[k][m_len[k]-4+j] != m_pat[k][3-j]) hit = 0;
        m_z[k] = hit;
        if (hit) begin
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          if (!i_overlap_en) m_len[k] = 0;
        end
      end else begin
        m_z[k] = 0;
      end
    end
    if (i_reset) m_ok = 1'b1;
  end

  int zc0 = 0, zc1 = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("z0",   o_z0,   m_z[0]);
      chk("pat0", o_pat0, m_pat[0]);
      chk("cnt0", o_cnt0, CE ? m_cnt[0] : 0);
      chk("sat0", o_sat0, CE ? int'(m_cnt[0] == cmax[0]) : 0);
      chk("z1",   o_z1,   m_z[1]);
      chk("pat1", o_pat1, m_pat[1]);
      chk("cnt1", o_cnt1, CE ? m_cnt[1] : 0);
      chk("sat1", o_sat1, CE ? int'(m_cnt[1] == cmax[1]) : 0);
      if (o_z0) zc0++;
      if (o_z1) zc1++;
    end
  end

  task automatic drive(input bit rst, input bit ld, input bit cl, input bit v,
                       input bit x, input logic [3:0] pin);
    i_reset = rst; i_pat_load = ld; i_clr = cl; i_x_valid = v; i_x = x;
    i_pat_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit x);
    drive(0, 0, 0, 1, x, 4'b0000);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1'b1, 4'b0000);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 1, 1'b1, 4'b1010);
  endtask

  task automatic send_seq(input logic [15:0] bits_v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      logic [15:0] t;
      t = bits_v;
      send(t[i]);
    end
  endtask

  int b0, b1;

  initial begin
    i_overlap_en = 1'b1;
    // reset with pat_load high: reset wins
    drive(1, 1, 1, 1, 1'b1, 4'b1010);
    chk("rst_pat0", o_pat0, 4'b0110);
    chk("rst_pat1", o_pat1, 4'b1111);
    chk("rst_z0", o_z0, 0);
    chk("rst_cnt0", o_cnt0, 0);

    // overlapping stream 0110110
    b0 = zc0;
    send_seq(16'b0110110, 7); idle();
    chk("ovl_pulses", zc0 - b0, 2);
    chk("ovl_cnt", o_cnt0, CE ? 2 : 0);

    // same stream, non-overlapping
    do_reset(); i_overlap_en = 1'b0;
    b0 = zc0;
    send_seq(16'b0110110, 7); idle();
    chk("novl_pulses", zc0 - b0, 1);
    chk("novl_cnt", o_cnt0, CE ? 1 : 0);
    i_overlap_en = 1'b1;

    // load 1011, stream 1,0,<stall x3>,1,1
    drive(0, 1, 0, 0, 1'b0, 4'b1011);
    chk("ld_pat", o_pat0, 4'b1011);
    b0 = zc0;
    send(1); send(0); idle(); idle(); idle();
    chk("stall_nopulse", zc0 - b0, 0);
    send(1); send(1); idle();
    chk("stall_pulse", zc0 - b0, 1);

    // reset mid-pattern, then one bit, then finish 0110 with three more
    do_reset();
    b0 = zc0;
    send_seq(16'b011, 3); do_reset(); send(0); idle();
    chk("rstmid_nopulse", zc0 - b0, 0);
    send_seq(16'b110, 3); idle();
    chk("rstmid_fill1", zc0 - b0, 1);

    // clr mid-pattern discards progress and its own bit
    do_reset();
    b0 = zc0;
    send_seq(16'b011, 3); drive(0, 0, 1, 1, 1'b0, 4'b0000); idle();
    chk("clr_nopulse", zc0 - b0, 0);
    send_seq(16'b0110, 4); idle();
    chk("clr_pulse", zc0 - b0, 1);

    // saturation on the CNT_W=2 instance: eight 1s
    do_reset();
    b0 = zc0; b1 = zc1;
    send_seq(16'hFF, 8); idle();
    chk("sat_pulses", zc1 - b1, 5);
    chk("sat_cnt", o_cnt1, CE ? 3 : 0);
    chk("sat_flag", o_sat1, CE ? 1 : 0);
    chk("sat_dut0_none", zc0 - b0, 0);

    // pat_load + clr + valid bit together
    drive(0, 1, 0, 0, 1'b0, 4'b1001);
    b0 = zc0;
    send_seq(16'b100, 3);
    drive(0, 1, 1, 1, 1'b1, 4'b1001);
    chk("ldclr_z", o_z0, 0);
    chk("ldclr_pat", o_pat0, 4'b1001);
    chk("ldclr_cnt1", o_cnt1, 0);
    idle();
    chk("ldclr_discard", zc0 - b0, 0);
    send_seq(16'b1001, 4); idle();
    chk("ldclr_after", zc0 - b0, 1);
    chk("ldclr_cnt0", o_cnt0, CE ? 1 : 0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 Parameter PAT_LEN, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match counter width; legal range 1..16.
REQ-003 Parameter PAT_RST, default 4'b0110 (zero-extended to PAT_LEN), pattern register value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  x is sampled on rising edge only when high.
REQ-008 pat_load  input  1  load pat_in into pattern register.
REQ-009 pat_in  input  PAT_LEN  new pattern; MSB is first bit in time.
REQ-010 overlap_en  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-011 clr  input  1  flush history and fill count; pattern and counter kept.
REQ-012 z  output  1  registered one-cycle match pulse.
REQ-013 match_cnt  output  CNT_W  number of matches since reset or pat_load.
REQ-014 cnt_sat  output  1  high while match_cnt is at all-ones.
REQ-015 pattern  output  PAT_LEN  current pattern register contents.

Function
REQ-016 Block SHALL hold a PAT_LEN-bit history shift register; each accepted bit (x_valid=1) shifts in at LSB, so the oldest bit is at MSB.
REQ-017 Block SHALL hold a fill counter, 0..PAT_LEN, that increments per accepted bit and saturates at PAT_LEN.
REQ-018 A match SHALL occur on an accepted bit when the history including that bit equals pattern and the fill count, including that bit, equals PAT_LEN.
REQ-019 z SHALL be high for exactly the one cycle after the clock edge that accepted the completing bit; z SHALL be low in all other cycles, including cycles with x_valid=0.
REQ-020 With overlap_en=1, history and fill SHALL be kept after a match (e.g. 0110 then 110 matches again).
REQ-021 With overlap_en=0, fill SHALL reset to 0 on a match, so the next match needs PAT_LEN new bits.
REQ-022 overlap_en SHALL be sampled on the same edge as the bit it qualifies; changes take effect immediately, with no pipeline.
REQ-023 pat_load=1 SHALL load pat_in into pattern, clear fill, clear match_cnt, and force z=0 on the next cycle.
REQ-024 Any x bit presented in the same cycle as pat_load SHALL be discarded.
REQ-025 clr=1 SHALL clear fill and force z=0 next cycle; a bit presented in the same cycle SHALL be discarded.
REQ-026 pat_load SHALL take priority over clr when both are high; reset SHALL take priority over both.
REQ-027 match_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1, never wrapping.
REQ-028 cnt_sat SHALL be a registered flag equal to (match_cnt == all-ones).
REQ-029 x_valid=0 cycles SHALL leave history, fill, and counter unchanged (stall-transparent).

Reset
REQ-030 On reset=1 at a rising edge: pattern=PAT_RST, history=0, fill=0, z=0, match_cnt=0, cnt_sat=0.
REQ-031 A reset asserted mid-pattern SHALL discard all partial progress; no match SHALL be reported using bits accepted before reset.
REQ-032 Other inputs SHALL be ignored during any cycle in which reset=1.

Configuration
REQ-033 Macro SEQDET_MATCH_COUNT_EN: when defined, the counter and cnt_sat SHALL be implemented per REQ-027/028.
REQ-034 When SEQDET_MATCH_COUNT_EN is undefined, match_cnt and cnt_sat SHALL be tied to constant 0, no counter flops SHALL exist, and z behaviour SHALL be identical.

Verification
REQ-035 Default params, overlap_en=1, x = 0,1,1,0,1,1,0 all valid -> z pulses after bits 4 and 7; match_cnt=2.
REQ-036 Same stream with overlap_en=0 -> z pulses after bit 4 only; match_cnt=1.
REQ-037 pat_load with pat_in=4'b1011, then x = 1,0,x_valid=0 for 3 cycles, then 1,1 -> single z pulse after the last bit; no pulse during the stall cycles.
REQ-038 x = 0,1,1, then reset=1 for one cycle, then x=0 -> no z; fill=1 after the final bit.
REQ-039 CNT_W=2, overlap_en=1, pattern 4'b1111, 8 consecutive valid 1s -> 5 z pulses; match_cnt stops at 3; cnt_sat=1 from the third match onward.
REQ-040 pat_load and clr high with x_valid=1 in the same cycle -> pattern updated, match_cnt=0, z=0 next cycle, bit discarded.
